// File: rtl/mc_control_sequencer.sv
//------------------------------------------------------------------------------
// mc_control_sequencer
//
// Multi-cycle fetch/decode/control stage for the 8-bit microprocessor. It sits
// directly upstream of the 4x8 register file. Instructions are fetched through
// a valid/ready port into the instruction register (IR). Data-memory accesses
// are sequenced through a req/ack handshake that has a bounded wait.
//
// ISA: IR[7:6] op, IR[5:4] rs, IR[3:2] rt, IR[1:0] rd/imm2
//   00 ADD  rd <- rs + rt
//   01 LW   rt <- mem[rs + sext(imm2)]
//   10 SW   mem[rs + sext(imm2)] <- rt
//   11 JMP  pc <- pc + sext(IR[5:0])   (pc already points past the JMP)
//
// Parameters:
//   PC_RESET     pc value loaded on reset
//   MEM_TIMEOUT  cycles mem_req may wait for mem_ack before abort (1..255)
//
// Optional build macro:
//   CTRL_RETIRE_COUNT_EN  adds output retire_count[15:0] (retired instructions)
//
// Ports:
//   CLK, reset                     clock (rising edge), async active-high reset
//   instr_valid/instr_data         instruction source
//   instr_ready                    high only in FETCH
//   pc                             address of next instruction to fetch
//   read_register_one/two          regfile read addresses (IR rs / IR rt)
//   read_data_one/two              regfile read data
//   write_register/write_data      regfile write address / data
//   RegWrite                       regfile write enable (one cycle in WB)
//   mem_req/mem_we/mem_addr/mem_wdata  data memory request
//   mem_rdata/mem_ack              data memory response
//   mem_err                        sticky memory-timeout flag
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mc_control_sequencer #(
    parameter logic [7:0]  PC_RESET    = 8'h00,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [7:0] instr_data,
    output logic       instr_ready,
    output logic [7:0] pc,
    output logic [1:0] read_register_one,
    output logic [1:0] read_register_two,
    input  logic [7:0] read_data_one,
    input  logic [7:0] read_data_two,
    output logic [1:0] write_register,
    output logic [7:0] write_data,
    output logic       RegWrite,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       mem_err
`ifdef CTRL_RETIRE_COUNT_EN
    ,
    output logic [15:0] retire_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_MEM    = 2'b10,
        S_WB     = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_JMP = 2'b11
    } op_t;

    // Last value of the wait counter before the access is abandoned.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_ir;
    logic [7:0] r_pc;
    logic [1:0] r_wreg;
    logic [7:0] r_wdata;
    logic       r_mem_req;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;
    logic       r_mem_err;
    logic [7:0] r_wait;

    op_t        w_op;
    logic [7:0] w_eff_addr;
    logic [7:0] w_jmp_pc;
    logic       w_ack_seen;
    logic       w_abort;

    //--------------------------------------------------------------------------
    // Decode helpers
    //--------------------------------------------------------------------------
    assign w_op       = op_t'(r_ir[7:6]);
    assign w_eff_addr = read_data_one + {{6{r_ir[1]}}, r_ir[1:0]};
    assign w_jmp_pc   = r_pc + {{2{r_ir[5]}}, r_ir[5:0]};

    // An ack only counts while a request is actually outstanding.
    assign w_ack_seen = (r_state == S_MEM) && r_mem_req && mem_ack;
    assign w_abort    = (r_state == S_MEM) && r_mem_req && !mem_ack &&
                        (r_wait == LP_WAIT_LAST);

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (instr_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_ADD:  w_next = S_WB;
                    OP_LW:   w_next = S_MEM;
                    OP_SW:   w_next = S_MEM;
                    OP_JMP:  w_next = S_FETCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (w_ack_seen) begin
                    w_next = r_mem_we ? S_FETCH : S_WB;
                end else if (w_abort) begin
                    w_next = S_FETCH;
                end
            end
            S_WB: begin
                w_next = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ir        <= '0;
            r_pc        <= PC_RESET;
            r_wreg      <= '0;
            r_wdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_err   <= 1'b0;
            r_wait      <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (instr_valid) begin
                        r_ir <= instr_data;
                        r_pc <= r_pc + 8'd1;
                    end
                end
                S_DECODE: begin
                    case (w_op)
                        OP_ADD: begin
                            r_wreg  <= r_ir[1:0];
                            r_wdata <= read_data_one + read_data_two;
                        end
                        OP_LW: begin
                            r_mem_addr <= w_eff_addr;
                            r_mem_we   <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_wreg     <= r_ir[3:2];
                            r_wait     <= '0;
                        end
                        OP_SW: begin
                            r_mem_addr  <= w_eff_addr;
                            r_mem_wdata <= read_data_two;
                            r_mem_we    <= 1'b1;
                            r_mem_req   <= 1'b1;
                            r_wait      <= '0;
                        end
                        OP_JMP: begin
                            r_pc <= w_jmp_pc;
                        end
                        default: begin
                        end
                    endcase
                end
                S_MEM: begin
                    if (w_ack_seen) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_wdata <= mem_rdata;
                        end
                    end else if (w_abort) begin
                        r_mem_req <= 1'b0;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CTRL_RETIRE_COUNT_EN
    //--------------------------------------------------------------------------
    // Retired-instruction counter: WB, SW ack, JMP decode, or timeout abort.
    //--------------------------------------------------------------------------
    logic [15:0] r_retire;
    logic        w_retire;

    assign w_retire = (r_state == S_WB) ||
                      (w_ack_seen && r_mem_we) ||
                      ((r_state == S_DECODE) && (w_op == OP_JMP)) ||
                      w_abort;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_retire <= '0;
        end else if (w_retire) begin
            r_retire <= r_retire + 16'd1;
        end
    end

    assign retire_count = r_retire;
`endif

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign instr_ready       = (r_state == S_FETCH);
    assign RegWrite          = (r_state == S_WB);
    assign pc                = r_pc;
    assign read_register_one = r_ir[5:4];
    assign read_register_two = r_ir[3:2];
    assign write_register    = r_wreg;
    assign write_data        = r_wdata;
    assign mem_req           = r_mem_req;
    assign mem_we            = r_mem_we;
    assign mem_addr          = r_mem_addr;
    assign mem_wdata         = r_mem_wdata;
    assign mem_err           = r_mem_err;

endmodule

// File: tb/tb_mc_control_sequencer.sv
//------------------------------------------------------------------------------
// tb_mc_control_sequencer
//
// Directed, table-driven bench for mc_control_sequencer. Each table record is
// one instruction: the register-file contents presented to the sequencer, the
// memory response, and the hand-computed outcome (cycle count, register write,
// memory request, pc, mem_err). Reset behaviour is covered by hand sequences.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mc_control_sequencer;

    logic       CLK = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic [7:0] pc;
    logic [1:0] read_register_one;
    logic [1:0] read_register_two;
    logic [7:0] read_data_one;
    logic [7:0] read_data_two;
    logic [1:0] write_register;
    logic [7:0] write_data;
    logic       RegWrite;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       mem_err;
`ifdef CTRL_RETIRE_COUNT_EN
    logic [15:0] retire_count;
`endif

    logic [7:0] rf [4];

    int n_cmp  = 0;
    int n_fail = 0;

    assign read_data_one = rf[read_register_one];
    assign read_data_two = rf[read_register_two];

    always #5 CLK = ~CLK;

    mc_control_sequencer #(
        .PC_RESET    (8'h00),
        .MEM_TIMEOUT (15)
    ) dut (
        .CLK               (CLK),
        .reset             (reset),
        .instr_valid       (instr_valid),
        .instr_data        (instr_data),
        .instr_ready       (instr_ready),
        .pc                (pc),
        .read_register_one (read_register_one),
        .read_register_two (read_register_two),
        .read_data_one     (read_data_one),
        .read_data_two     (read_data_two),
        .write_register    (write_register),
        .write_data        (write_data),
        .RegWrite          (RegWrite),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .mem_err           (mem_err)
`ifdef CTRL_RETIRE_COUNT_EN
        ,
        .retire_count      (retire_count)
`endif
    );

    typedef struct {
        logic [7:0]  instr;
        logic [31:0] rf;        // {r3, r2, r1, r0}
        int          ack_delay; // wait cycles before ack; 255 = never
        logic [7:0]  rdata;
        int          exp_cycles;
        int          exp_rw;    // number of RegWrite cycles
        int          exp_rw_cyc;
        logic [1:0]  exp_wreg;
        logic [7:0]  exp_wdata;
        int          exp_req;   // cycles mem_req is high
        logic [7:0]  exp_addr;
        logic        exp_we;
        logic [7:0]  exp_mwdata;
        logic [7:0]  exp_pc;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(
        input logic [7:0] instr, input logic [31:0] rfv, input int ack,
        input logic [7:0] rdata, input int cyc, input int rw, input int rw_cyc,
        input logic [1:0] wreg, input logic [7:0] wdata, input int req,
        input logic [7:0] addr, input logic we, input logic [7:0] mwd,
        input logic [7:0] pcv, input logic err);
        vec_t v;
        v.instr = instr;      v.rf = rfv;           v.ack_delay = ack;
        v.rdata = rdata;      v.exp_cycles = cyc;   v.exp_rw = rw;
        v.exp_rw_cyc = rw_cyc; v.exp_wreg = wreg;   v.exp_wdata = wdata;
        v.exp_req = req;      v.exp_addr = addr;    v.exp_we = we;
        v.exp_mwdata = mwd;   v.exp_pc = pcv;       v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH and checks its outcome.
    task automatic run_vec(input int idx, input vec_t v);
        int         cyc;
        int         rw_n;
        int         rw_cyc;
        int         req_n;
        logic [1:0] wr;
        logic [7:0] wd;
        logic [7:0] ma;
        logic [7:0] mwd;
        logic       mwe;
        logic       unstable;
        cyc = 1; rw_n = 0; rw_cyc = 0; req_n = 0;
        wr = '0; wd = '0; ma = '0; mwd = '0; mwe = 1'b0; unstable = 1'b0;
        for (int r = 0; r < 4; r++) rf[r] = v.rf[8*r +: 8];
        mem_rdata = v.rdata;
        chk($sformatf("v%0d.ready_at_fetch", idx), instr_ready, 1);
        instr_valid = 1'b1;
        instr_data  = v.instr;
        @(negedge CLK);
        instr_valid = 1'b0;
        instr_data  = 8'hFF;
        while (!instr_ready && cyc < 100) begin
            cyc++;
            if (RegWrite) begin
                rw_n++;
                rw_cyc = cyc;
                wr = write_register;
                wd = write_data;
            end
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    ma = mem_addr; mwe = mem_we; mwd = mem_wdata;
                end else if (mem_addr != ma || mem_we != mwe || mem_wdata != mwd) begin
                    unstable = 1'b1;
                end
            end
            mem_ack = mem_req && (req_n == v.ack_delay + 1);
            @(negedge CLK);
        end
        mem_ack = 1'b0;
        chk($sformatf("v%0d.cycles", idx), cyc, v.exp_cycles);
        chk($sformatf("v%0d.regwrite_cycles", idx), rw_n, v.exp_rw);
        if (v.exp_rw > 0) begin
            chk($sformatf("v%0d.regwrite_at", idx), rw_cyc, v.exp_rw_cyc);
            chk($sformatf("v%0d.write_register", idx), wr, v.exp_wreg);
            chk($sformatf("v%0d.write_data", idx), wd, v.exp_wdata);
        end
        chk($sformatf("v%0d.mem_req_cycles", idx), req_n, v.exp_req);
        if (v.exp_req > 0) begin
            chk($sformatf("v%0d.mem_addr", idx), ma, v.exp_addr);
            chk($sformatf("v%0d.mem_we", idx), mwe, v.exp_we);
            if (v.exp_we) chk($sformatf("v%0d.mem_wdata", idx), mwd, v.exp_mwdata);
            chk($sformatf("v%0d.mem_stable", idx), unstable, 0);
        end
        chk($sformatf("v%0d.pc", idx), pc, v.exp_pc);
        chk($sformatf("v%0d.mem_err", idx), mem_err, v.exp_err);
    endtask

    vec_t vecs [13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        instr  rf{r3,r2,r1,r0} ack rdata cyc rw rwc wr wdata req addr  we mwd   pc   err
        vecs[0]  = mk(8'h1B, 32'h0020F000, 0,   8'h00, 3,  1, 3,  3, 8'h10, 0,  8'h00, 0, 8'h00, 8'h01, 0); // ADD r3=r1+r2 wraps
        vecs[1]  = mk(8'h5B, 32'h00001000, 3,   8'hA5, 7,  1, 7,  2, 8'hA5, 4,  8'h0F, 0, 8'h00, 8'h02, 0); // LW r2,[r1-1]
        vecs[2]  = mk(8'hA5, 32'h00307700, 0,   8'h00, 3,  0, 0,  0, 8'h00, 1,  8'h31, 1, 8'h77, 8'h03, 0); // SW r1,[r2+1]
        vecs[3]  = mk(8'h0D, 32'h80000080, 0,   8'h00, 3,  1, 3,  1, 8'h00, 0,  8'h00, 0, 8'h00, 8'h04, 0); // ADD r1=r0+r3 -> 00
        vecs[4]  = mk(8'h71, 32'hFF000000, 0,   8'h3C, 4,  1, 4,  0, 8'h3C, 1,  8'h00, 0, 8'h00, 8'h05, 0); // LW r0,[r3+1] addr wraps
        vecs[5]  = mk(8'h82, 32'h00000001, 255, 8'h00, 17, 0, 0,  0, 8'h00, 15, 8'hFF, 1, 8'h01, 8'h06, 1); // SW timeout
        vecs[6]  = mk(8'h1B, 32'h00020100, 0,   8'h00, 3,  1, 3,  3, 8'h03, 0,  8'h00, 0, 8'h00, 8'h07, 1); // ADD after abort
        vecs[7]  = mk(8'h5B, 32'h00001000, 255, 8'h00, 17, 0, 0,  0, 8'h00, 15, 8'h0F, 0, 8'h00, 8'h08, 1); // LW timeout
        vecs[8]  = mk(8'hF7, 32'h00000000, 0,   8'h00, 2,  0, 0,  0, 8'h00, 0,  8'h00, 0, 8'h00, 8'h00, 1); // JMP -9
        vecs[9]  = mk(8'hFF, 32'h00000000, 0,   8'h00, 2,  0, 0,  0, 8'h00, 0,  8'h00, 0, 8'h00, 8'h00, 1); // JMP -1
        vecs[10] = mk(8'hFF, 32'h00000000, 0,   8'h00, 2,  0, 0,  0, 8'h00, 0,  8'h00, 0, 8'h00, 8'h00, 1); // JMP -1
        vecs[11] = mk(8'hFD, 32'h00000000, 0,   8'h00, 2,  0, 0,  0, 8'h00, 0,  8'h00, 0, 8'h00, 8'hFE, 1); // JMP -3
        vecs[12] = mk(8'hDF, 32'h00000000, 0,   8'h00, 2,  0, 0,  0, 8'h00, 0,  8'h00, 0, 8'h00, 8'h1E, 1); // JMP +31 wraps

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_data  = 8'h00;
        mem_rdata   = 8'h00;
        mem_ack     = 1'b0;
        for (int r = 0; r < 4; r++) rf[r] = 8'h00;

        // Reset values while reset is held.
        @(negedge CLK);
        chk("rst.pc", pc, 8'h00);
        chk("rst.instr_ready", instr_ready, 1);
        chk("rst.regwrite", RegWrite, 0);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.mem_addr", mem_addr, 8'h00);
        chk("rst.mem_wdata", mem_wdata, 8'h00);
        chk("rst.write_register", write_register, 2'b00);
        chk("rst.write_data", write_data, 8'h00);
        chk("rst.mem_err", mem_err, 0);
        chk("rst.read_regs", {read_register_one, read_register_two}, 4'h0);
        @(negedge CLK);
        reset = 1'b0;

        // Idle FETCH for 5 cycles; a stray ack in the middle is ignored.
        for (int i = 0; i < 5; i++) begin
            mem_ack = (i == 2);
            @(negedge CLK);
            chk($sformatf("idle%0d.pc", i), pc, 8'h00);
            chk($sformatf("idle%0d.instr_ready", i), instr_ready, 1);
            chk($sformatf("idle%0d.regwrite", i), RegWrite, 0);
            chk($sformatf("idle%0d.mem_req", i), mem_req, 0);
        end
        mem_ack = 1'b0;
        chk("idle.mem_err", mem_err, 0);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

`ifdef CTRL_RETIRE_COUNT_EN
        chk("retire_count.after_table", retire_count, 16'd13);
`endif

        // Reset asserted mid-MEM with a request outstanding.
        rf[1] = 8'h10;
        instr_valid = 1'b1;
        instr_data  = 8'h5B;
        @(negedge CLK);
        instr_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge CLK);
        @(negedge CLK);
        chk("mr.mem_req_before", mem_req, 1);
        chk("mr.mem_err_before", mem_err, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr.mem_req", mem_req, 0);
        chk("mr.regwrite", RegWrite, 0);
        chk("mr.instr_ready", instr_ready, 1);
        chk("mr.pc", pc, 8'h00);
        chk("mr.mem_err", mem_err, 0);
`ifdef CTRL_RETIRE_COUNT_EN
        chk("mr.retire_count", retire_count, 16'd0);
`endif
        @(negedge CLK);
        chk("mr.regwrite_held", RegWrite, 0);
        reset = 1'b0;
        @(negedge CLK);

        run_vec(13, mk(8'h1B, 32'h0020F000, 0, 8'h00, 3, 1, 3, 3, 8'h10, 0,
                       8'h00, 0, 8'h00, 8'h01, 0));
`ifdef CTRL_RETIRE_COUNT_EN
        chk("retire_count.after_reset", retire_count, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_sequencer.md
Name: mc_control_sequencer

Overview:
- Multi-cycle fetch/decode/control stage for the 8-bit microprocessor, directly upstream of the 4x8 register file.
- Fetches instructions through a valid/ready port and holds them in an instruction register (IR).
- Drives the register file's read/write addresses, write data and RegWrite, and sequences data-memory accesses through a req/ack handshake.
- ISA: IR[7:6] op, IR[5:4] rs, IR[3:2] rt, IR[1:0] rd/imm2.

Parameters:
PC_RESET, 8'h00, PC value loaded on reset
MEM_TIMEOUT, 15, max cycles mem_req waits for mem_ack before abort (1..255)

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
instr_valid  in  1  instruction source has instr_data
instr_data  in  8  instruction word
instr_ready  out  1  sequencer accepts instruction this cycle
pc  out  8  address of next instruction to fetch
read_register_one  out  2  regfile read address 1 (IR rs)
read_register_two  out  2  regfile read address 2 (IR rt)
read_data_one  in  8  regfile data 1
read_data_two  in  8  regfile data 2
write_register  out  2  regfile write address
write_data  out  8  regfile write data
RegWrite  out  1  regfile write enable
mem_req  out  1  data memory request
mem_we  out  1  1=store, 0=load
mem_addr  out  8  data memory address
mem_wdata  out  8  store data
mem_rdata  in  8  load data, valid with mem_ack
mem_ack  in  1  memory completes request
mem_err  out  1  sticky: a memory access timed out

Behaviour:
- Reset (async) values: state FETCH, pc=PC_RESET, IR=0, instr_ready=1, RegWrite=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, write_register=0, write_data=0, mem_err=0.
- Reset mid-operation aborts everything: pending mem_req drops immediately and no register write occurs.
- States: FETCH, DECODE, MEM, WB.
- FETCH:
  - instr_ready=1.
  - On instr_valid=1 at a clock edge: IR<=instr_data, pc<=pc+1 (mod 256), go to DECODE.
  - Otherwise stay in FETCH.
- read_register_one/two = IR[5:4]/IR[3:2] combinationally, valid from DECODE onward.
- DECODE: latch A<=read_data_one, B<=read_data_two, then branch on op:
  - 00 ADD: go to WB; write_register<=IR[1:0]; write_data<=A+B, 8-bit wrap, carry discarded.
  - 01 LW: mem_addr<=read_data_one+sext(IR[1:0]) mod 256; mem_we<=0; mem_req<=1; go to MEM; write_register<=IR[3:2].
  - 10 SW: same address calculation; mem_wdata<=read_data_two; mem_we<=1; mem_req<=1; go to MEM.
  - 11 JMP: pc<=pc+sext(IR[5:0]) mod 256, where pc is already IR address+1; go to FETCH.
- MEM:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
  - On ack: mem_req<=0. LW latches write_data<=mem_rdata and goes to WB; SW goes to FETCH.
  - mem_ack while mem_req=0 is ignored.
  - Timeout: if MEM_TIMEOUT cycles elapse with no ack, set mem_req<=0 and mem_err<=1, go to FETCH, no register write. mem_err clears only on reset.
- WB: RegWrite=1 for exactly one cycle (Moore on state), then FETCH.
- Cycle counts with zero fetch stall:
  - ADD: 3
  - JMP: 2
  - LW: 4 + ack wait
  - SW: 3 + ack wait
- Ack on the first MEM cycle counts as zero wait.
- instr_ready=0 in every state other than FETCH. instr_data presented outside FETCH is not consumed.
- Register-file hazards are impossible: each writeback completes before the next fetch.

Optional Feature:
- Macro: CTRL_RETIRE_COUNT_EN.
- Defined: adds output retire_count[15:0], reset 0.
  - Increments by 1 when an instruction retires: on the WB cycle, the SW ack cycle, the JMP DECODE cycle, or the timeout-abort cycle.
  - Wraps at 16'hFFFF->0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then instr_valid=0 for 5 cycles -> pc=00, instr_ready=1, RegWrite=0, mem_req=0 throughout.
- Regfile r1=8'hF0, r2=8'h20; feed ADD r3=r1+r2 (8'b00_01_10_11) -> RegWrite for exactly one cycle, 2 cycles after fetch; write_register=3, write_data=8'h10; pc=01.
- r1=8'h10; LW r2,[r1-1] (8'b01_01_10_11); memory acks after 3 cycles with 8'hA5 -> mem_addr=8'h0F, mem_we=0, mem_req held 4 cycles; then write_register=2, write_data=A5.
- SW with mem_ack never asserted, MEM_TIMEOUT=15 -> mem_req drops after 15 cycles, mem_err=1 and stays 1, no RegWrite, next FETCH proceeds.
- At pc=00 feed JMP -1 (8'hFF) -> pc returns to 00, 2 cycles per iteration. Then JMP +31 (8'hDF) at pc=FE -> pc wraps to 1E.
- Assert reset during MEM with mem_req=1 -> mem_req and RegWrite drop immediately, state FETCH, pc=PC_RESET. If CTRL_RETIRE_COUNT_EN is defined, retire_count=0.
